pc_redirect_unit: RTL

//  Program-counter generator and control-flow redirect stage, directly downstream of the branch comparator.

---
 rtl/pc_redirect_unit_pkg.sv | 7 +
 rtl/pc_redirect_unit_br_target_gen.sv | 18 +
 rtl/pc_redirect_unit.sv | 109 ++++++++++
 3 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: shared FSM state encoding and PC constants for the PC redirect stage
package pc_redirect_unit_pkg;
    typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_FLUSH, ST_TRAP} state_t;
    localparam logic [31:0] PC_STEP     = 32'd4;
    localparam logic [31:0] IALIGN_MASK = 32'hFFFF_FFFC;
    localparam logic [31:0] JALR_MASK   = 32'hFFFF_FFFE;
endpackage

// File: rtl/pc_redirect_unit_br_target_gen.sv
// pc_redirect_unit_br_target_gen: combinational redirect target and link address
//   ex_pc, imm, rs1 : EX-stage PC, sign-extended immediate, JALR base
//   is_jalr         : select rs1-based target (bit 0 cleared) over PC-relative target
//   target          : raw taken target, before alignment handling
//   link            : ex_pc + 4 for rd writeback
module pc_redirect_unit_br_target_gen
    import pc_redirect_unit_pkg::*;
(
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        is_jalr,
    output logic [31:0] target,
    output logic [31:0] link
);
    assign target = is_jalr ? (rs1 + imm) & JALR_MASK : ex_pc + imm;
    assign link   = ex_pc + PC_STEP;
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: PC generator and control-flow redirect stage feeding fetch
//   clk, RSTn (sync, active-low)
//   ex_valid, is_branch, is_jal, is_jalr, Br_en, ex_pc, imm, rs1 : EX-stage redirect info
//   stall, if_ready : hold PC / fetch accepts pc_o
//   pc_o, pc_valid  : fetch PC stream
//   flush_o         : squash IF/ID, held FLUSH_CYCLES cycles after a redirect
//   link_o          : ex_pc + 4 (combinational)
//   trap_o, bad_addr: misaligned-target trap; only live with PC_MISALIGN_TRAP_EN defined
// Optional feature macro: PC_MISALIGN_TRAP_EN
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          FLUSH_CYCLES = 2,
    parameter logic [31:0] TRAP_VEC     = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        RSTn,
    input  logic        ex_valid,
    input  logic        is_branch,
    input  logic        is_jal,
    input  logic        is_jalr,
    input  logic        Br_en,
    input  logic [31:0] ex_pc,
    input  logic [31:0] imm,
    input  logic [31:0] rs1,
    input  logic        stall,
    input  logic        if_ready,
    output logic [31:0] pc_o,
    output logic        pc_valid,
    output logic        flush_o,
    output logic [31:0] link_o,
    output logic        trap_o,
    output logic [31:0] bad_addr
);
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t      state, state_nx;
    logic [2:0]  cnt, cnt_nx;
    logic [31:0] pc_nx, raw_target, target;
    logic        taken, misalign;

    pc_redirect_unit_br_target_gen u_tgt (
        .ex_pc   (ex_pc),
        .imm     (imm),
        .rs1     (rs1),
        .is_jalr (is_jalr),
        .target  (raw_target),
        .link    (link_o)
    );

    // is_jalr already steers the target mux, giving jalr > jal > branch priority
    assign taken = ex_valid & (is_jal | is_jalr | (is_branch & Br_en));

`ifdef PC_MISALIGN_TRAP_EN
    assign misalign = raw_target[1];
    assign target   = raw_target;
    assign trap_o   = state == ST_TRAP;
    always_ff @(posedge clk)
        if (!RSTn)
            bad_addr <= '0;
        else if (state == ST_RUN && taken && misalign)
            bad_addr <= raw_target;
`else
    // Without the trap, misaligned targets are silently aligned down
    assign misalign = 1'b0;
    assign target   = raw_target & IALIGN_MASK;
    assign trap_o   = 1'b0;
    assign bad_addr = '0;
`endif

    assign pc_valid = state == ST_RUN;
    assign flush_o  = state == ST_FLUSH || state == ST_TRAP;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        pc_nx    = pc_o;
        unique case (state)
            ST_BOOT: state_nx = ST_RUN;
            ST_RUN:
                if (taken) begin
                    // Redirect beats stall: stall only gates the sequential increment
                    state_nx = misalign ? ST_TRAP : ST_FLUSH;
                    pc_nx    = misalign ? TRAP_VEC : target;
                    cnt_nx   = CNT_INIT;
                end else if (if_ready && !stall) begin
                    pc_nx = pc_o + PC_STEP;
                end
            ST_FLUSH: begin
                state_nx = cnt == 3'd0 ? ST_RUN : ST_FLUSH;
                cnt_nx   = cnt == 3'd0 ? cnt : cnt - 3'd1;
            end
            ST_TRAP: state_nx = ST_FLUSH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!RSTn) begin
            state <= ST_BOOT;
            cnt   <= '0;
            pc_o  <= RESET_PC;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            pc_o  <= pc_nx;
        end
    end
endmodule
